// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct constants, ALU-op and mux-select encodings, the control
// vector carried from the output decoder to the top, and a retire helper.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_EXEC_ORI = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14,
        S_UNUSED   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FUNCT_JR = 6'd8;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    // True when the instruction completes on the edge that leaves this state.
    // MEM_WR only completes once memory accepts the write.
    function automatic logic retires(input state_t s, input logic mem_ready);
        logic r;
        case (s)
            S_MEM_WB, S_R_WB, S_I_WB,
            S_BRANCH, S_JUMP, S_JR:  r = 1'b1;
            S_MEM_WR:                r = mem_ready;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational control-vector decode for the multicycle control unit.
// Ports: state (current FSM state), opcode (IR[31:26], selects beq/bne
// polarity), mem_ready (qualifies IR/PC load in FETCH), active (low forces
// every control to 0, used while reset is asserted), ctrl (control vector).
module mcu_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       active,
    output ctrl_t      ctrl
);

    // Moore decode of the state; only FETCH's IR/PC load looks at mem_ready.
    always_comb begin
        ctrl = '0;
        if (active) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRC_B_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_src    = PC_SRC_ALU;
                    if (mem_ready) begin
                        ctrl.ir_write = 1'b1;
                        ctrl.pc_write = 1'b1;
                    end else begin
                        ctrl.ir_write = 1'b0;
                        ctrl.pc_write = 1'b0;
                    end
                end
                S_DECODE: begin
                    // Speculative branch target PC+4+(imm<<2) into ALUOut.
                    ctrl.alu_src_b = SRC_B_IMM_SH2;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_ADDR, S_EXEC_I: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_EXEC_ORI: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_OR;
                end
                S_MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                S_EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRC_B_RT;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                S_I_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRC_B_RT;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_src        = PC_SRC_ALUOUT;
                    ctrl.branch_ne     = (opcode == OP_BNE);
                end
                S_JUMP: begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_JUMP;
                end
                S_JR: begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_RS;
                end
                S_TRAP: begin
                    ctrl.illegal = 1'b1;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end else begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// handshakes with a unified memory (mem_read/mem_write held until
// mem_ready), traps unsupported opcodes and counts retired instructions.
// Ports: clk, rst_n (async active-low), opcode/funct from IR, mem_ready;
// datapath controls (mem_read, mem_write, iord, ir_write, pc_write,
// pc_write_cond, branch_ne, pc_src, alu_src_a, alu_src_b, alu_op, reg_dst,
// mem_to_reg, reg_write), illegal pulse, instr_count, state_o (debug).
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_count,
    output logic [3:0]         state_o
);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] count_r;
    ctrl_t            ctrl_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; memory states wait on mem_ready, others advance.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) state_next_s = S_DECODE;
                else           state_next_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FUNCT_JR) state_next_s = S_JR;
                        else                   state_next_s = S_EXEC_R;
                    end
                    OP_LW, OP_SW:   state_next_s = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
                    OP_ADDI:        state_next_s = S_EXEC_I;
                    OP_ORI:         state_next_s = S_EXEC_ORI;
                    OP_J:           state_next_s = S_JUMP;
                    default:        state_next_s = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) state_next_s = S_MEM_RD;
                else                 state_next_s = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready) state_next_s = S_MEM_WB;
                else           state_next_s = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready) state_next_s = S_FETCH;
                else           state_next_s = S_MEM_WR;
            end
            S_EXEC_R:               state_next_s = S_R_WB;
            S_EXEC_I, S_EXEC_ORI:   state_next_s = S_I_WB;
            default:                state_next_s = S_FETCH;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (retires(state_r, mem_ready)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // rst_n gates the decoder so a pending request drops the instant reset hits.
    mcu_output_decode u_decode (
        .state     (state_r),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .active    (rst_n),
        .ctrl      (ctrl_s)
    );

    assign mem_read      = ctrl_s.mem_read;
    assign mem_write     = ctrl_s.mem_write;
    assign iord          = ctrl_s.iord;
    assign ir_write      = ctrl_s.ir_write;
    assign pc_write      = ctrl_s.pc_write;
    assign pc_write_cond = ctrl_s.pc_write_cond;
    assign branch_ne     = ctrl_s.branch_ne;
    assign pc_src        = ctrl_s.pc_src;
    assign alu_src_a     = ctrl_s.alu_src_a;
    assign alu_src_b     = ctrl_s.alu_src_b;
    assign alu_op        = ALUOP_W'(ctrl_s.alu_op);
    assign reg_dst       = ctrl_s.reg_dst;
    assign mem_to_reg    = ctrl_s.mem_to_reg;
    assign reg_write     = ctrl_s.reg_write;
    assign illegal       = ctrl_s.illegal;
    assign instr_count   = count_r;
    assign state_o       = state_r;

endmodule
